complement2_serial: RTL and testbench
=====================================

// Module: complement2_serial
// PURPOSE
//  Multi-cycle, parametrised two's-complement unit for the FP datapath (mantissa/exponent sign handling).
//  Processes CHUNK bits per cycle, rippling the +1 carry between chunks through a register.
//  Wide negations therefore use a CHUNK-bit adder instead of a full WIDTH-bit carry chain.
//  Four modes (pass, negate, abs, sign-magnitude->two's complement) with valid/ready handshakes on both sides.
// PARAMETERS
//  WIDTH   25  operand/result width in bits (>=2)
//  CHUNK   5   bits processed per cycle; WIDTH % CHUNK == 0 required; NCHUNK = WIDTH/CHUNK
// PORTS
//  clk       in   1      clock, rising edge
//  rst_n     in   1      asynchronous active-low reset
//  in_valid  in   1      operand valid
//  in_ready  out  1      unit idle, operand accepted when in_valid & in_ready
//  in_data   in   WIDTH  operand
//  in_mode   in   2      00 pass, 01 negate, 10 abs (signed), 11 sign-magnitude -> two's complement
//  out_valid out  1      result valid, held until out_ready
//  out_ready in   1      downstream accepts result when out_valid & out_ready
//  out_data  out  WIDTH  result
//  out_ovf   out  1      result not representable (negate/abs of most-negative value)
//  busy      out  1      state != IDLE
// BEHAVIOUR
//  - FSM states: IDLE -> RUN -> DONE -> IDLE. Only one operation is in flight; there is no overlap of accept and output.
//  - Reset (async, rst_n low): state=IDLE; out_valid=0, out_data=0, out_ovf=0, busy=0; internal regs cleared.
//    A reset mid-RUN or mid-DONE aborts the operation and discards the result.
//  - in_ready = (state==IDLE), decoded from state; it reads 1 during and after reset. in_valid is ignored outside IDLE.
//  - Accept edge (IDLE, in_valid=1): latch src and inv, set carry=inv, chunk index k=0, go to RUN.
//    src = in_data, except mode 11, where MSB is forced to 0.
//    inv: mode 00 -> 0; mode 01 -> 1; mode 10 -> in_data[WIDTH-1]; mode 11 -> in_data[WIDTH-1].
//  - RUN, each cycle k (k = 0..NCHUNK-1, LSB chunk first):
//    {c, r} = (src[k*CHUNK +: CHUNK] ^ {CHUNK{inv}}) + carry.
//    Write r into result[k*CHUNK +: CHUNK]; carry <= c; k <= k+1. After k = NCHUNK-1, go to DONE.
//  - The final carry-out is discarded; arithmetic is modulo 2^WIDTH.
//  - Latency: out_valid rises exactly NCHUNK cycles after the accept edge (CHUNK==WIDTH -> 1 cycle).
//  - DONE: out_valid=1; out_data and out_ovf stay stable while out_ready=0. On out_valid & out_ready, go to IDLE with out_valid=0.
//    in_ready returns 1 in the following cycle.
//  - out_data updates only on the DONE entry edge and keeps its last value in IDLE/RUN.
//  - out_ovf = inv & src[WIDTH-1] & result[WIDTH-1]. This is 1 only for negate/abs of 1000...0.
//    In that case the result equals the input. It is always 0 in modes 00 and 11.
//  - Mode 11: -0 (1000...0) yields 0 with out_ovf=0; +m yields m; -m yields two's complement of m.
//  - Any in_mode value is legal; in_mode and in_data are sampled only on the accept edge.
// TESTING (WIDTH=25, CHUNK=5 unless noted)
//  1. negate 25'h0000020 -> 25'h1FFFFE0, ovf=0; out_valid exactly 5 cycles after accept. Checks carry ripple across chunk 0.
//  2. negate 25'h1000000 -> 25'h1000000, ovf=1; abs 25'h1000000 -> same, ovf=1; negate 0 -> 0, ovf=0.
//  3. abs 25'h1FFFFFB -> 25'h0000005; abs 25'h0000007 -> 25'h0000007; pass 25'h0ABCDEF -> 25'h0ABCDEF.
//  4. mode 11: 25'h1000003 -> 25'h1FFFFFD; 25'h1000000 -> 0 (ovf=0); 25'h0000003 -> 25'h0000003.
//  5. Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid/out_data/out_ovf stable, in_ready=0.
//     in_valid pulses during that window are not accepted. Back-to-back ops with out_ready=1 -> one result per 7 cycles.
//  6. Drop rst_n during RUN at k=2 -> outputs 0 immediately, IDLE, no out_valid. Repeat test 1 with CHUNK=25 -> latency 1.

Source files
------------

// File: rtl/complement2_serial_if.sv
// rtl/complement2_serial_if.sv - operand/result handshake bundle for complement2_serial
interface complement2_serial_if #(
  parameter int WIDTH = 25
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_ovf;

  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/complement2_serial.sv
// rtl/complement2_serial.sv - chunk-serial two's-complement unit (pass/negate/abs/sign-magnitude)
module complement2_serial #(
  parameter int WIDTH = 25,
  parameter int CHUNK = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  complement2_serial_if.slave  io,
  output logic                 busy
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] M_PASS   = 2'b00;
  localparam logic [1:0] M_NEGATE = 2'b01;
  localparam logic [1:0] M_SMAG   = 2'b11;

  logic [1:0]       state_q,    state_d;
  logic [WIDTH-1:0] src_q,      src_d;
  logic             inv_q,      inv_d;
  logic             carry_q,    carry_d;
  logic [KW-1:0]    k_q,        k_d;
  logic [WIDTH-1:0] result_q,   result_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_ovf_q,  out_ovf_d;

  logic [31:0]      shamt;
  logic [CHUNK-1:0] chunk_in;
  logic [CHUNK:0]   sum;
  logic [WIDTH-1:0] chunk_mask;
  logic [WIDTH-1:0] res_merge;

  // Shifting instead of a variable part-select keeps the datapath legal when NCHUNK==1.
  assign shamt      = 32'(k_q) * 32'(CHUNK);
  assign chunk_in   = CHUNK'(src_q >> shamt);
  assign sum        = {1'b0, chunk_in ^ {CHUNK{inv_q}}} + {{CHUNK{1'b0}}, carry_q};
  assign chunk_mask = WIDTH'({CHUNK{1'b1}});
  assign res_merge  = (result_q & ~(chunk_mask << shamt)) | (WIDTH'(sum[CHUNK-1:0]) << shamt);

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    inv_d      = inv_q;
    carry_d    = carry_q;
    k_d        = k_q;
    result_d   = result_q;
    out_data_d = out_data_q;
    out_ovf_d  = out_ovf_q;
    case (state_q)
      S_IDLE: begin
        if (io.in_valid) begin
          if (io.in_mode == M_SMAG) begin
            src_d = {1'b0, io.in_data[WIDTH-2:0]};
          end else begin
            src_d = io.in_data;
          end
          case (io.in_mode)
            M_PASS:   inv_d = 1'b0;
            M_NEGATE: inv_d = 1'b1;
            default:  inv_d = io.in_data[WIDTH-1];
          endcase
          carry_d = inv_d;
          k_d     = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        result_d = res_merge;
        carry_d  = sum[CHUNK];
        k_d      = k_q + KW'(1);
        if (k_q == K_LAST) begin
          // Result and overflow flag are published together on DONE entry only.
          out_data_d = res_merge;
          out_ovf_d  = inv_q & src_q[WIDTH-1] & res_merge[WIDTH-1];
          k_d        = '0;
          state_d    = S_DONE;
        end
      end
      S_DONE: begin
        if (io.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      src_q      <= '0;
      inv_q      <= 1'b0;
      carry_q    <= 1'b0;
      k_q        <= '0;
      result_q   <= '0;
      out_data_q <= '0;
      out_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      inv_q      <= inv_d;
      carry_q    <= carry_d;
      k_q        <= k_d;
      result_q   <= result_d;
      out_data_q <= out_data_d;
      out_ovf_q  <= out_ovf_d;
    end
  end

  assign io.in_ready  = (state_q == S_IDLE);
  assign io.out_valid = (state_q == S_DONE);
  assign io.out_data  = out_data_q;
  assign io.out_ovf   = out_ovf_q;
  assign busy         = (state_q != S_IDLE);
endmodule

// File: tb/tb_complement2_serial.sv
// tb/tb_complement2_serial.sv - directed vector bench for complement2_serial
module tb_complement2_serial;
  localparam int W = 25;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  complement2_serial_if #(.WIDTH(W)) a ();
  complement2_serial_if #(.WIDTH(W)) b ();
  logic busy_a, busy_b;

  complement2_serial #(.WIDTH(W), .CHUNK(5)) dut_a (
    .clk(clk), .rst_n(rst_n), .io(a.slave), .busy(busy_a)
  );
  complement2_serial #(.WIDTH(W), .CHUNK(25)) dut_b (
    .clk(clk), .rst_n(rst_n), .io(b.slave), .busy(busy_b)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]   mode;
    logic [W-1:0] data;
    logic [W-1:0] exp_data;
    logic         exp_ovf;
  } vec_t;

  vec_t vecs[12];

  task automatic run_a(input logic [1:0] mode, input logic [W-1:0] data,
                       output int lat, output logic [W-1:0] d, output logic o);
    int cnt;
    cnt = 0;
    while (!a.in_ready && cnt < 20) begin @(negedge clk); cnt++; end
    a.in_valid = 1'b1; a.in_mode = mode; a.in_data = data;
    @(posedge clk); @(negedge clk);
    a.in_valid = 1'b0;
    cnt = 0;
    while (!a.out_valid && cnt < 40) begin @(posedge clk); cnt++; @(negedge clk); end
    lat = cnt; d = a.out_data; o = a.out_ovf;
    a.out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    a.out_ready = 1'b0;
  endtask

  task automatic run_b(input logic [1:0] mode, input logic [W-1:0] data,
                       output int lat, output logic [W-1:0] d, output logic o);
    int cnt;
    cnt = 0;
    while (!b.in_ready && cnt < 20) begin @(negedge clk); cnt++; end
    b.in_valid = 1'b1; b.in_mode = mode; b.in_data = data;
    @(posedge clk); @(negedge clk);
    b.in_valid = 1'b0;
    cnt = 0;
    while (!b.out_valid && cnt < 40) begin @(posedge clk); cnt++; @(negedge clk); end
    lat = cnt; d = b.out_data; o = b.out_ovf;
    b.out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    b.out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    logic [W-1:0] d;
    logic o;
    int cnt;
    int seen_valid;
    int times[$];

    vecs[0]  = '{2'b01, 25'h0000020, 25'h1FFFFE0, 1'b0};
    vecs[1]  = '{2'b01, 25'h1000000, 25'h1000000, 1'b1};
    vecs[2]  = '{2'b10, 25'h1000000, 25'h1000000, 1'b1};
    vecs[3]  = '{2'b01, 25'h0000000, 25'h0000000, 1'b0};
    vecs[4]  = '{2'b10, 25'h1FFFFFB, 25'h0000005, 1'b0};
    vecs[5]  = '{2'b10, 25'h0000007, 25'h0000007, 1'b0};
    vecs[6]  = '{2'b00, 25'h0ABCDEF, 25'h0ABCDEF, 1'b0};
    vecs[7]  = '{2'b11, 25'h1000003, 25'h1FFFFFD, 1'b0};
    vecs[8]  = '{2'b11, 25'h1000000, 25'h0000000, 1'b0};
    vecs[9]  = '{2'b11, 25'h0000003, 25'h0000003, 1'b0};
    vecs[10] = '{2'b01, 25'h0ABCDEF, 25'h1543211, 1'b0};
    vecs[11] = '{2'b00, 25'h1000000, 25'h1000000, 1'b0};

    a.in_valid = 1'b0; a.in_mode = 2'b00; a.in_data = '0; a.out_ready = 1'b0;
    b.in_valid = 1'b0; b.in_mode = 2'b00; b.in_data = '0; b.out_ready = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_in_ready", {31'd0, a.in_ready}, 32'd1);
    check("reset_outputs", {4'd0, busy_a, a.out_valid, a.out_ovf, a.out_data}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", {4'd0, busy_a, a.in_ready, a.out_valid, a.out_data}, {4'd0, 3'b010, 25'd0});

    for (int i = 0; i < 12; i++) begin
      run_a(vecs[i].mode, vecs[i].data, lat, d, o);
      check($sformatf("vec%0d_data", i), {7'd0, d}, {7'd0, vecs[i].exp_data});
      check($sformatf("vec%0d_ovf", i), {31'd0, o}, {31'd0, vecs[i].exp_ovf});
      check($sformatf("vec%0d_latency", i), lat, 32'd5);
      check($sformatf("vec%0d_in_ready_after", i), {31'd0, a.in_ready}, 32'd1);
    end

    // Backpressure: hold DONE for 10 cycles while poking in_valid.
    a.in_valid = 1'b1; a.in_mode = 2'b01; a.in_data = 25'h0000020;
    @(posedge clk); @(negedge clk);
    a.in_valid = 1'b0;
    cnt = 0;
    while (!a.out_valid && cnt < 40) begin @(posedge clk); cnt++; @(negedge clk); end
    for (int i = 0; i < 10; i++) begin
      a.in_valid = i[0]; a.in_mode = 2'b01; a.in_data = 25'h0001234;
      @(posedge clk); @(negedge clk);
      check($sformatf("bp_hold%0d", i),
            {4'd0, a.out_valid, a.in_ready, a.out_ovf, a.out_data},
            {4'd0, 3'b100, 25'h1FFFFE0});
    end
    a.in_valid = 1'b0;
    a.out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    a.out_ready = 1'b0;
    check("bp_release", {30'd0, a.out_valid, a.in_ready}, 32'd1);
    seen_valid = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); @(negedge clk);
      if (a.out_valid || busy_a) seen_valid++;
    end
    check("bp_no_phantom_op", seen_valid, 32'd0);

    // Back-to-back with permanent in_valid/out_ready.
    a.in_valid = 1'b1; a.in_mode = 2'b01; a.in_data = 25'h0000020; a.out_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); @(negedge clk);
      if (a.out_valid) begin
        times.push_back(c);
        check($sformatf("b2b_data%0d", c), {7'd0, a.out_data}, {7'd0, 25'h1FFFFE0});
      end
    end
    a.in_valid = 1'b0;
    repeat (10) begin @(posedge clk); @(negedge clk); end
    a.out_ready = 1'b0;
    check("b2b_count", times.size(), 32'd5);
    for (int i = 1; i < times.size(); i++) begin
      check($sformatf("b2b_period%0d", i), times[i] - times[i-1], 32'd7);
    end

    // Reset while RUN is on chunk 2.
    check("pre_reset_out_data", {7'd0, a.out_data}, {7'd0, 25'h1FFFFE0});
    a.in_valid = 1'b1; a.in_mode = 2'b01; a.in_data = 25'h0000055;
    @(posedge clk); @(negedge clk);
    a.in_valid = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrun_reset_outputs",
          {4'd0, busy_a, a.in_ready, a.out_valid, a.out_ovf, a.out_data} >> 0,
          {4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 25'd0} >> 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); @(negedge clk);
      if (a.out_valid) seen_valid++;
    end
    check("midrun_reset_no_valid", seen_valid, 32'd0);

    // Single-chunk instance: whole word in one cycle.
    run_b(2'b01, 25'h0000020, lat, d, o);
    check("chunk25_data", {7'd0, d}, {7'd0, 25'h1FFFFE0});
    check("chunk25_ovf", {31'd0, o}, 32'd0);
    check("chunk25_latency", lat, 32'd1);
    run_b(2'b10, 25'h1000000, lat, d, o);
    check("chunk25_abs_min", {6'd0, o, d}, {6'd0, 1'b1, 25'h1000000});
    check("chunk25_busy_idle", {31'd0, busy_b}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
